// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache and D-cache line transfers onto one banked main-memory port.
// Ports: clk/rst (sync, active-high); i_req/d_req, d_wr, i_addr/d_addr, d_wdata from the cache controllers;
//        gnt_i/gnt_d, widx, rvalid/rdata/ridx, i_done/d_done back to them;
//        mem_rd/mem_wr/mem_addr/mem_data_in/mem_stall/mem_data_out to main memory.
// Config: define MEM_ARB_RR_EN to alternate between sides on simultaneous requests (default: D wins).
module mem_arbiter #(
   parameter int RD_LAT = 2,
   parameter int BURST  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] i_addr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        gnt_i,
   output logic        gnt_d,
   output logic [1:0]  widx,
   output logic        rvalid,
   output logic [15:0] rdata,
   output logic [1:0]  ridx,
   output logic        i_done,
   output logic        d_done,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   input  logic        mem_stall,
   input  logic [15:0] mem_data_out
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   // pipe pattern where only the final read of the burst is still in flight and about to emerge
   localparam logic [RD_LAT-1:0] VTOP = RD_LAT'(1) << (RD_LAT - 1);
   state_t            state_q;
   logic [1:0]        cnt_q;
   logic [15:3]       line_q;
   logic              wr_q;
   logic              gnt_i_q, gnt_d_q, i_done_q, d_done_q;
   logic [RD_LAT-1:0] vp_q;
   logic [1:0]        ip_q [RD_LAT];
   logic              issue, acc, last_word, pick_d;
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[2:0], d_addr[2:0]};
   assign issue     = state_q == ISSUE;
   assign acc       = issue && !mem_stall;
   assign last_word = cnt_q == 2'(BURST - 1);
`ifdef MEM_ARB_RR_EN
   logic last_d_q;
   // on a tie, serve whichever side did not own the previous burst
   assign pick_d = d_req && (!i_req || !last_d_q);
`else
   assign pick_d = d_req;
`endif
   assign gnt_i       = gnt_i_q;
   assign gnt_d       = gnt_d_q;
   assign i_done      = i_done_q;
   assign d_done      = d_done_q;
   assign mem_rd      = issue && !wr_q;
   assign mem_wr      = issue && wr_q;
   assign mem_addr    = issue ? {line_q, cnt_q, 1'b0} : '0;
   assign widx        = mem_wr ? cnt_q : '0;
   assign mem_data_in = mem_wr ? d_wdata : '0;
   assign rvalid      = vp_q[RD_LAT-1];
   assign ridx        = rvalid ? ip_q[RD_LAT-1] : '0;
   assign rdata       = rvalid ? mem_data_out : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         line_q   <= '0;
         wr_q     <= 1'b0;
         gnt_i_q  <= 1'b0;
         gnt_d_q  <= 1'b0;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_d_q <= 1'b0;
`endif
      end else begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         case (state_q)
            IDLE: if (i_req || d_req) begin
               state_q <= ISSUE;
               cnt_q   <= '0;
               gnt_d_q <= pick_d;
               gnt_i_q <= !pick_d;
               wr_q    <= pick_d && d_wr;
               line_q  <= pick_d ? d_addr[15:3] : i_addr[15:3];
`ifdef MEM_ARB_RR_EN
               last_d_q <= pick_d;
`endif
            end
            ISSUE: if (acc) begin
               cnt_q <= cnt_q + 2'd1;
               if (last_word) begin
                  state_q  <= wr_q ? DONE : DRAIN;
                  i_done_q <= wr_q && gnt_i_q;
                  d_done_q <= wr_q && gnt_d_q;
               end
            end
            DRAIN: if (vp_q == VTOP) begin
               state_q  <= DONE;
               i_done_q <= gnt_i_q;
               d_done_q <= gnt_d_q;
            end
            DONE: begin
               state_q <= IDLE;
               gnt_i_q <= 1'b0;
               gnt_d_q <= 1'b0;
            end
         endcase
      end
   end
   // read-return pipe: one valid bit and word index per accepted read, RD_LAT deep
   always_ff @(posedge clk) begin
      if (rst) begin
         vp_q <= '0;
      end else begin
         vp_q[0] <= acc && !wr_q;
         ip_q[0] <= cnt_q;
         for (int k = 1; k < RD_LAT; k++) begin
            vp_q[k] <= vp_q[k-1];
            ip_q[k] <= ip_q[k-1];
         end
      end
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning cycles from an accepted memory read to valid mem_data_out (legal 1..4).
REQ-002 SHALL have parameter BURST, default 4, meaning 16-bit words per cache-line transfer (fixed power of two).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports i_req/d_req  in  1  line-transfer request from the I-cache/D-cache controller, held until the matching done.
REQ-006 SHALL have port d_wr  in  1  D-side transfer is a writeback (1) or fill (0); the I side is fill-only.
REQ-007 SHALL have ports i_addr/d_addr  in  16  line address; bits [2:0] ignored.
REQ-008 SHALL have port d_wdata  in  16  writeback word selected by widx, supplied combinationally in the same cycle.
REQ-009 SHALL have ports gnt_i/gnt_d  out  1  owner of the current burst, one-hot or zero.
REQ-010 SHALL have port widx  out  2  word index of the writeback word being issued.
REQ-011 SHALL have ports rvalid  out  1, rdata  out  16, ridx  out  2  returned fill word, its data and its index, routed to the granted side.
REQ-012 SHALL have ports i_done/d_done  out  1  one-cycle pulse at burst completion.
REQ-013 SHALL have ports mem_rd, mem_wr  out  1; mem_addr, mem_data_in  out  16; mem_stall  in  1; mem_data_out  in  16  interface to the banked main memory.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE: on any req, latch owner, line address and direction, assert the matching gnt, go to ISSUE next cycle.
REQ-016 Simultaneous i_req and d_req SHALL grant D (fixed priority) unless CONFIG (REQ-027) applies.
REQ-017 ISSUE: SHALL drive mem_addr = {line[15:3], cnt[1:0], 1'b0} with exactly one of mem_rd/mem_wr; cnt advances only when mem_stall=0 in that cycle.
REQ-018 mem_stall=1 SHALL hold address, data and strobe unchanged for a retry the next cycle; the word SHALL NOT be counted.
REQ-019 Writeback: mem_data_in = d_wdata, widx = cnt; after word BURST-1 is accepted go to DONE.
REQ-020 Fill: after word BURST-1 is accepted go to DRAIN; each accepted read enters an RD_LAT-deep valid/index shift pipe.
REQ-021 rvalid SHALL assert exactly RD_LAT cycles after each accepted read, with rdata = mem_data_out and ridx = that word's cnt; out-of-order return is impossible.
REQ-022 DRAIN: go to DONE in the cycle after the last pipe entry emerges.
REQ-023 DONE: pulse the owner's done for one cycle, deassert gnt, return to IDLE; no new grant in the DONE cycle.
REQ-024 The line address and owner SHALL stay latched for the whole burst even if the requester changes inputs.
REQ-025 Outside ISSUE, mem_rd = mem_wr = 0; gnt SHALL remain asserted from the ISSUE entry through DONE.

Reset
REQ-026 rst SHALL force IDLE, cnt = 0, an empty pipe, and all outputs 0 on the next edge, including mid-burst; the aborted burst SHALL produce no done and no late rvalid.

Configuration
REQ-027 MEM_ARB_RR_EN defined: on simultaneous requests, grant the side not served by the most recent burst (last-owner flag reset to I, so D wins first); undefined: fixed D priority per REQ-016.

Verification
REQ-028 I fill at 0x0040, no stall, RD_LAT=2 -> mem_addr 0x40,42,44,46 on 4 consecutive cycles; rvalid ridx 0..3 two cycles later; i_done 1 cycle after the last rvalid.
REQ-029 D writeback at 0x1238 with d_wdata=0xA000+widx -> mem_wr writes 0x1238..0x123E with 0xA000..0xA003; d_done pulses; no rvalid.
REQ-030 mem_stall high for 3 cycles on word 1 of a fill -> addr 0x..2 held for 4 cycles; ridx sequence still 0..3 with no duplicates.
REQ-031 i_req and d_req both held continuously -> without the macro only D bursts are served; with MEM_ARB_RR_EN the sequence is D,I,D,I.
REQ-032 rst asserted during DRAIN -> next cycle all outputs 0, no done or rvalid afterward; a new request is served normally.
REQ-033 New req asserted in the DONE cycle -> granted the following cycle (IDLE), never in DONE.
